// File: rtl/clause_array_loader.sv
// clause_array_loader
//   Moves clauses between an upstream stream and an attached clause array.
//   A load accepts cnt_i clauses over a valid/ready handshake and writes
//   each into the next array slot with a one-hot strobe. A store reads cnt_i
//   slots back and offers each downstream over a valid/ready handshake.
//
//   Optional feature: define CLAUSE_LOADER_CLEAR_EN to zero the slots left
//   unwritten after a short load (adds the CLEAR state).
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   start_load_i/start_store_i  start pulses (accepted only when idle)
//   cnt_i                     clause count, saturated to NUM_CLAUSES
//   in_valid_i/in_ready_o     upstream handshake; in_clause_i, in_len_i payload
//   wr_o/rd_o                 one-hot slot write/read strobes to the array
//   clause_o/clause_len_o     write data to the array (zero when not writing)
//   clause_i                  array read data, valid one cycle after rd_o
//   out_valid_o/out_ready_i   downstream handshake; out_clause_o payload
//   busy_o, done_o            operation in progress; one-cycle completion pulse
module clause_array_loader #(
    parameter int unsigned NUM_CLAUSES = 8,
    parameter int unsigned NUM_VARS    = 8,
    parameter int unsigned WIDTH_C_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_load_i,
    input  logic                   start_store_i,
    input  logic [WIDTH_C_LEN-1:0] cnt_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NUM_VARS*2-1:0]  in_clause_i,
    input  logic [WIDTH_C_LEN-1:0] in_len_i,
    output logic [NUM_CLAUSES-1:0] wr_o,
    output logic [NUM_CLAUSES-1:0] rd_o,
    output logic [NUM_VARS*2-1:0]  clause_o,
    output logic [WIDTH_C_LEN-1:0] clause_len_o,
    input  logic [NUM_VARS*2-1:0]  clause_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [NUM_VARS*2-1:0]  out_clause_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned CW = NUM_VARS * 2;
    localparam int unsigned SW = $clog2(NUM_CLAUSES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef CLAUSE_LOADER_CLEAR_EN
        CLEAR,
`endif
        RD,
        WAIT,
        OUT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0]          slot_q, slot_d;
    logic [SW-1:0]          num_q, num_d;
    logic [SW-1:0]          eff_cnt;
    logic                   in_ready_d;
    logic [NUM_CLAUSES-1:0] wr_d, rd_d;
    logic [CW-1:0]          clause_d;
    logic [WIDTH_C_LEN-1:0] len_d;
    logic                   out_valid_d;
    logic [CW-1:0]          out_clause_d;
    logic                   busy_d, done_d;

    function automatic logic [NUM_CLAUSES-1:0] onehot(input logic [SW-1:0] idx);
        return NUM_CLAUSES'(1) << idx;
    endfunction

    // Requested count saturated to the number of slots.
    always_comb begin
        if (32'(cnt_i) > 32'(NUM_CLAUSES)) begin
            eff_cnt = SW'(NUM_CLAUSES);
        end else begin
            eff_cnt = SW'(cnt_i);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            num_q        <= '0;
            in_ready_o   <= 1'b0;
            wr_o         <= '0;
            rd_o         <= '0;
            clause_o     <= '0;
            clause_len_o <= '0;
            out_valid_o  <= 1'b0;
            out_clause_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            num_q        <= num_d;
            in_ready_o   <= in_ready_d;
            wr_o         <= wr_d;
            rd_o         <= rd_d;
            clause_o     <= clause_d;
            clause_len_o <= len_d;
            out_valid_o  <= out_valid_d;
            out_clause_o <= out_clause_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
        end
    end

    // Next state and next output values; every strobe lasts one cycle.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        num_d        = num_q;
        wr_d         = '0;
        rd_d         = '0;
        clause_d     = '0;
        len_d        = '0;
        out_valid_d  = 1'b0;
        out_clause_d = '0;

        case (state_q)
            IDLE: begin
                if (start_load_i || start_store_i) begin
                    num_d  = eff_cnt;
                    slot_d = '0;
                    if (eff_cnt == '0) begin
                        state_d = DONE;
                    end else if (start_load_i) begin
                        state_d = LOAD;
                    end else begin
                        state_d = RD;
                        rd_d    = onehot('0);
                    end
                end
            end

            LOAD: begin
                if (in_valid_i && in_ready_o) begin
                    wr_d     = onehot(slot_q);
                    clause_d = in_clause_i;
                    len_d    = in_len_i;
                    slot_d   = slot_q + SW'(1);
                end else if (slot_q == num_q) begin
                    // Final write is on wr_o during this cycle.
`ifdef CLAUSE_LOADER_CLEAR_EN
                    if (slot_q < SW'(NUM_CLAUSES)) begin
                        state_d = CLEAR;
                        wr_d    = onehot(slot_q);
                        slot_d  = slot_q + SW'(1);
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end

`ifdef CLAUSE_LOADER_CLEAR_EN
            CLEAR: begin
                // Zero-write the remaining slots back to back.
                if (slot_q < SW'(NUM_CLAUSES)) begin
                    wr_d   = onehot(slot_q);
                    slot_d = slot_q + SW'(1);
                end else begin
                    state_d = DONE;
                end
            end
`endif

            RD: begin
                state_d = WAIT;
            end

            WAIT: begin
                // Array data for the slot read last cycle is on clause_i now.
                out_clause_d = clause_i;
                out_valid_d  = 1'b1;
                state_d      = OUT;
            end

            OUT: begin
                if (out_ready_i) begin
                    slot_d = slot_q + SW'(1);
                    if ((slot_q + SW'(1)) < num_q) begin
                        state_d = RD;
                        rd_d    = onehot(slot_q + SW'(1));
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    out_valid_d  = 1'b1;
                    out_clause_d = out_clause_o;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready drops once every requested clause has been transferred.
        in_ready_d = (state_d == LOAD) && (slot_d < num_d);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

endmodule

// File: tb/tb_clause_array_loader.sv
// Testbench for clause_array_loader: a cycle-accurate transaction model of
// the loader drives per-cycle expectations; directed tests add literal checks.
module tb_clause_array_loader;

    localparam int NC = 8;
    localparam int CW = 16;
    localparam int LW = 4;

    logic          clk;
    logic          rst;
    logic          start_load, start_store;
    logic [LW-1:0] cnt;
    logic          in_valid, in_ready;
    logic [CW-1:0] in_clause;
    logic [LW-1:0] in_len;
    logic [NC-1:0] wr, rd;
    logic [CW-1:0] clause;
    logic [LW-1:0] clause_len;
    logic [CW-1:0] clause_rdata;
    logic          out_valid, out_ready;
    logic [CW-1:0] out_clause;
    logic          busy, done;

    clause_array_loader #(.NUM_CLAUSES(NC), .NUM_VARS(CW/2), .WIDTH_C_LEN(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_load_i (start_load),
        .start_store_i(start_store),
        .cnt_i        (cnt),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_clause_i  (in_clause),
        .in_len_i     (in_len),
        .wr_o         (wr),
        .rd_o         (rd),
        .clause_o     (clause),
        .clause_len_o (clause_len),
        .clause_i     (clause_rdata),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_clause_o (out_clause),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Attached array stub: registered read, contents set by the bench.
    logic [CW-1:0] arr [NC];
    always @(posedge clk) begin
        for (int k = 0; k < NC; k++) begin
            if (rd[k]) clause_rdata <= arr[k];
        end
    end

    // Cycle index: value seen at a negedge is the number of posedges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the loader's externally visible behaviour.
    typedef struct {
        int            due;
        int            slot;
        logic [CW-1:0] data;
        logic [LW-1:0] len;
    } wr_t;
    wr_t wq[$];

    localparam int INF = 32'h3fff_ffff;
    bit m_active, m_loading, m_storing;
    int m_n, m_xf, m_k, m_done, m_rd, m_ovs, m_c;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_loading = 0; m_storing = 0;
            m_done = -100; m_rd = -100; m_ovs = INF;
            wq.delete();
        end else begin
            m_c = cyc + 1;
            if (!m_active) begin
                if (start_load || start_store) begin
                    m_n = (int'(cnt) > NC) ? NC : int'(cnt);
                    m_active = 1; m_xf = 0; m_k = 0;
                    if (m_n == 0) m_done = m_c;
                    else if (start_load) m_loading = 1;
                    else begin
                        m_storing = 1; m_rd = m_c; m_ovs = m_c + 2;
                    end
                end
            end else begin
                if (m_loading && m_xf < m_n && in_valid) begin
                    wq.push_back('{due: m_c, slot: m_xf, data: in_clause, len: in_len});
                    m_xf++;
                    if (m_xf == m_n) begin
                        m_loading = 0;
                        m_done = m_c + 1;
`ifdef CLAUSE_LOADER_CLEAR_EN
                        for (int j = m_n; j < NC; j++)
                            wq.push_back('{due: m_c + 1 + j - m_n, slot: j, data: '0, len: '0});
                        m_done = m_c + 1 + NC - m_n;
`endif
                    end
                end
                if (m_storing && (m_c - 1) >= m_ovs && out_ready) begin
                    m_k++;
                    if (m_k < m_n) begin
                        m_rd = m_c; m_ovs = m_c + 2;
                    end else begin
                        m_storing = 0; m_ovs = INF; m_done = m_c;
                    end
                end
                if (m_done == m_c - 1) m_active = 0;
            end
            while (wq.size() > 0 && wq[0].due < m_c) void'(wq.pop_front());
        end
    end

    // Compare every DUT output against the model once per cycle.
    logic [NC-1:0] e_wr, e_rd;
    logic [CW-1:0] e_cl;
    logic [LW-1:0] e_ln;
    logic          e_ov;
    always @(negedge clk) begin
        e_wr = '0; e_cl = '0; e_ln = '0;
        if (wq.size() > 0 && wq[0].due == cyc) begin
            e_wr = NC'(1) << wq[0].slot;
            e_cl = wq[0].data;
            e_ln = wq[0].len;
        end
        e_rd = (m_storing && m_rd == cyc) ? (NC'(1) << m_k) : '0;
        e_ov = m_storing && (cyc >= m_ovs);
        chk("wr_o", 32'(wr), 32'(e_wr));
        chk("clause_o", 32'(clause), 32'(e_cl));
        chk("clause_len_o", 32'(clause_len), 32'(e_ln));
        chk("rd_o", 32'(rd), 32'(e_rd));
        chk("in_ready_o", 32'(in_ready), 32'(m_loading && m_xf < m_n));
        chk("out_valid_o", 32'(out_valid), 32'(e_ov));
        if (e_ov) chk("out_clause_o", 32'(out_clause), 32'(arr[m_k]));
        chk("busy_o", 32'(busy), 32'(m_active));
        chk("done_o", 32'(done), 32'(m_active && m_done == cyc));
    end

    function automatic logic [CW-1:0] pat(input int i);
        return CW'(32'hC0DE + i * 32'h1111);
    endfunction

    logic [NC-1:0] cap_wr [NC];
    logic [CW-1:0] cap_cl [NC];

    task automatic start_op(input bit ld, input bit st, input int c);
        @(negedge clk);
        start_load = ld; start_store = st; cnt = LW'(c);
        @(negedge clk);
        start_load = 0; start_store = 0; cnt = '0;
    endtask

    // Present n clauses; optional single bubble before clause gap_at.
    task automatic feed(input int n, input int gap_at);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                in_valid = 0;
                @(negedge clk);
            end
            in_valid = 1; in_clause = pat(i); in_len = LW'(i + 1);
            ok = 0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(posedge clk);
                ok = in_ready;
            end
            if (!ok) chk("feed_timeout", 0, 1);
            @(negedge clk);
            cap_wr[i] = wr; cap_cl[i] = clause;
            chk("lit_wr_after_xfer", 32'(wr), 32'(NC'(1) << i));
        end
        in_valid = 0; in_clause = '0; in_len = '0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int t = 0; t < budget && !ok; t++) begin
            if (done) ok = 1;
            else @(negedge clk);
        end
        if (!ok) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("lit_idle_after_done", 32'(busy), 0);
    endtask

    task automatic store_op(input int c, input int hold);
        int nn;
        bit ok;
        nn = (c > NC) ? NC : c;
        start_op(0, 1, c);
        for (int k = 0; k < nn; k++) begin
            ok = 0;
            for (int t = 0; t < 10 && !ok; t++) begin
                if (out_valid) ok = 1;
                else @(negedge clk);
            end
            if (!ok) chk("valid_timeout", 0, 1);
            for (int h = 0; h < hold; h++) begin
                chk("lit_hold_valid", 32'(out_valid), 1);
                chk("lit_hold_data", 32'(out_clause), 32'(arr[k]));
                chk("lit_no_rd_while_held", 32'(rd), 0);
                @(negedge clk);
            end
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
            if (k + 1 < nn) chk("lit_rd_after_accept", 32'(rd), 32'(NC'(1) << (k + 1)));
        end
        wait_done(10);
    endtask

    initial begin
        rst = 0; start_load = 0; start_store = 0; cnt = '0;
        in_valid = 0; in_clause = '0; in_len = '0; out_ready = 0;
        for (int k = 0; k < NC; k++) arr[k] = CW'(32'h1000 + k * 32'h0101);
        arr[0] = 16'h5A5A;
        arr[1] = 16'h0F0F;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr", 32'(wr), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        rst = 1;

        // Load 3 clauses, valid held high
        start_op(1, 0, 3);
        feed(3, -1);
        chk("t1_wr0", 32'(cap_wr[0]), 32'h01);
        chk("t1_wr1", 32'(cap_wr[1]), 32'h02);
        chk("t1_wr2", 32'(cap_wr[2]), 32'h04);
        chk("t1_cl0", 32'(cap_cl[0]), 32'hC0DE);
        chk("t1_cl2", 32'(cap_cl[2]), 32'hE300);
`ifndef CLAUSE_LOADER_CLEAR_EN
        @(negedge clk);
        chk("t1_done_after_last", 32'(done), 1);
`endif
        wait_done(20);

        // Store 2 clauses with downstream back-pressure
        store_op(2, 3);

        // Zero count and saturated count
        start_op(1, 0, 0);
        chk("t3_cnt0_done", 32'(done), 1);
        chk("t3_cnt0_wr", 32'(wr), 0);
        wait_done(5);
        start_op(1, 0, 12);
        feed(8, -1);
        chk("t3_sat_first", 32'(cap_wr[0]), 32'h01);
        chk("t3_sat_last", 32'(cap_wr[7]), 32'h80);
        wait_done(10);
        start_op(0, 1, 0);
        chk("t3_store0_done", 32'(done), 1);
        wait_done(5);

        // Simultaneous starts, start during busy, bubble in the stream
        start_op(1, 1, 2);
        start_store = 1; cnt = LW'(5);
        chk("t4_busy", 32'(busy), 1);
        @(negedge clk);
        start_store = 0; cnt = '0;
        feed(2, 1);
        chk("t4_wr1", 32'(cap_wr[1]), 32'h02);
        wait_done(20);

        // Reset during the second of four loads
        start_op(1, 0, 4);
        in_valid = 1; in_clause = pat(0); in_len = 4'd1;
        @(negedge clk);
        in_clause = pat(1); in_len = 4'd2;
        #2 rst = 0;
        #1;
        chk("t5_rst_wr", 32'(wr), 0);
        chk("t5_rst_clause", 32'(clause), 0);
        chk("t5_rst_ready", 32'(in_ready), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        in_valid = 0; in_clause = '0; in_len = '0;
        @(negedge clk);
        rst = 1;
        repeat (6) @(negedge clk);
        chk("t5_no_done", 32'(done), 0);
        start_op(1, 0, 2);
        feed(2, -1);
        wait_done(20);

        // Load 5: remaining slots zeroed when clearing is enabled
        start_op(1, 0, 5);
        feed(5, -1);
`ifdef CLAUSE_LOADER_CLEAR_EN
        @(negedge clk);
        chk("t6_clr5", 32'(wr), 32'h20);
        chk("t6_clr5_data", 32'(clause), 0);
        @(negedge clk);
        chk("t6_clr6", 32'(wr), 32'h40);
        @(negedge clk);
        chk("t6_clr7", 32'(wr), 32'h80);
        chk("t6_clr7_len", 32'(clause_len), 0);
`endif
        @(negedge clk);
        chk("t6_done", 32'(done), 1);
        wait_done(5);

        // Store 3 with immediate acceptance
        store_op(3, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
